// File: rtl/debug_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// debug_cfg_arbiter
//   Arbitrates the debug unit's configuration port (DCP/Sel) between the SPI
//   security engine, the external debugger and the on-chip CPU. The owner
//   streams (index, data) writes; each legal write is serialised as a
//   header / data / gap triple on DCP. Illegal writes and idle grants set a
//   sticky per-requester error flag.
//
// Ports
//   clk        system clock
//   MRST       asynchronous active-high reset
//   req[2:0]   access request (0 = CPU, 1 = debugger, 2 = SPI)
//   wr_valid   per-requester write valid
//   wr_idx     per-requester 4-bit CFR index, requester i at [4i+3:4i]
//   wr_data    per-requester 32-bit data, requester i at [32i+31:32i]
//   wr_last    per-requester last-write-of-burst marker
//   gnt        one-hot grant
//   wr_ready   write accepted this cycle (owner only, in GRANT)
//   DCP        debug configuration port
//   Sel        owner code: 00 none, 01 CPU, 10 debugger, 11 SPI
//   busy       a grant is active
//   err        sticky per-requester error flags
//   clr_err    synchronous clear of err (a same-cycle set wins)
//   wcount     wrapping count of writes issued on DCP
// -----------------------------------------------------------------------------

// Per-requester slice: ready decode and sticky error flag.
module debug_cfg_lane (
   input  logic clk,
   input  logic MRST,
   input  logic i_own,       // this lane holds the grant
   input  logic i_in_grant,  // FSM is in GRANT
   input  logic i_err_evt,   // error event for the current owner
   input  logic i_clr_err,
   output logic o_wr_ready,
   output logic o_err
);
   logic r_err;

   assign o_wr_ready = i_own & i_in_grant;
   assign o_err      = r_err;

   always_ff @(posedge clk or posedge MRST) begin
      if (MRST)                    r_err <= 1'b0;
      else if (i_err_evt && i_own) r_err <= 1'b1;   // set wins over clear
      else if (i_clr_err)          r_err <= 1'b0;
   end
endmodule

module debug_cfg_arbiter #(
   parameter int NCFR    = 10,
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        MRST,
   input  logic [2:0]  req,
   input  logic [2:0]  wr_valid,
   input  logic [11:0] wr_idx,
   input  logic [95:0] wr_data,
   input  logic [2:0]  wr_last,
   output logic [2:0]  gnt,
   output logic [2:0]  wr_ready,
   output logic [31:0] DCP,
   output logic [1:0]  Sel,
   output logic        busy,
   output logic [2:0]  err,
   input  logic        clr_err,
   output logic [15:0] wcount
);
   localparam int NREQ = 3;
   localparam int CW   = $clog2(TIMEOUT + 1);
   localparam logic [4:0]    NCFR_L   = 5'(NCFR);
   localparam logic [CW-1:0] ICNT_MAX = CW'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_GRANT = 3'd1;
   localparam logic [2:0] S_HDR   = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;
   localparam logic [2:0] S_REL   = 3'd5;

   logic [2:0]    r_state, w_next;
   logic [1:0]    r_owner;
   logic [2:0]    r_gnt;
   logic [1:0]    r_sel;
   logic          r_busy;
   logic [3:0]    r_idx;
   logic [31:0]   r_data;
   logic          r_last;
   logic [CW-1:0] r_icnt;
   logic [15:0]   r_wcount;

   // Owner-selected request lane
   logic        w_req, w_valid, w_last;
   logic [3:0]  w_idx;
   logic [31:0] w_data;
   logic [1:0]  w_pick;
   logic        w_in_grant, w_hs, w_legal, w_timeout, w_drop, w_err_evt;

   always_comb begin
      w_req   = 1'b0;
      w_valid = 1'b0;
      w_last  = 1'b0;
      w_idx   = 4'd0;
      w_data  = 32'd0;
      case (r_owner)
         2'd0: begin
            w_req = req[0]; w_valid = wr_valid[0]; w_last = wr_last[0];
            w_idx = wr_idx[3:0];  w_data = wr_data[31:0];
         end
         2'd1: begin
            w_req = req[1]; w_valid = wr_valid[1]; w_last = wr_last[1];
            w_idx = wr_idx[7:4];  w_data = wr_data[63:32];
         end
         2'd2: begin
            w_req = req[2]; w_valid = wr_valid[2]; w_last = wr_last[2];
            w_idx = wr_idx[11:8]; w_data = wr_data[95:64];
         end
         default: ;
      endcase
   end

   // Fixed priority: SPI > debugger > CPU
   always_comb begin
      if (req[2])      w_pick = 2'd2;
      else if (req[1]) w_pick = 2'd1;
      else             w_pick = 2'd0;
   end

   assign w_in_grant = (r_state == S_GRANT);
   assign w_hs       = w_in_grant & w_valid;
   assign w_legal    = ({1'b0, w_idx} < NCFR_L) & ~w_data[31];
   assign w_drop     = w_in_grant & ~w_valid & ~w_req;
   // Counter holds the number of idle GRANT cycles already elapsed, so this
   // cycle is the TIMEOUT-th one when it equals TIMEOUT-1.
   assign w_timeout  = w_in_grant & ~w_valid & (r_icnt == ICNT_MAX);
   assign w_err_evt  = (w_hs & ~w_legal) | w_timeout;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (|req) w_next = S_GRANT;
         S_GRANT: begin
            if (w_valid) begin
               if (w_legal)     w_next = S_HDR;
               else if (w_last) w_next = S_REL;
            end else if (w_drop || w_timeout) begin
               w_next = S_REL;
            end
         end
         S_HDR:   w_next = S_DATA;
         S_DATA:  w_next = S_GAP;
         S_GAP:   w_next = r_last ? S_REL : S_GRANT;
         S_REL:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge MRST) begin
      if (MRST) begin
         r_state  <= S_IDLE;
         r_owner  <= 2'd0;
         r_gnt    <= 3'd0;
         r_sel    <= 2'd0;
         r_busy   <= 1'b0;
         r_idx    <= 4'd0;
         r_data   <= 32'd0;
         r_last   <= 1'b0;
         r_icnt   <= '0;
         r_wcount <= 16'd0;
      end else begin
         r_state <= w_next;

         if (r_state == S_IDLE && |req) begin
            r_owner <= w_pick;
            r_gnt   <= 3'b001 << w_pick;
            r_sel   <= w_pick + 2'd1;
            r_busy  <= 1'b1;
         end else if (w_next == S_REL) begin
            r_gnt  <= 3'd0;
            r_sel  <= 2'd0;
            r_busy <= 1'b0;
         end

         if (w_hs) begin
            r_idx  <= w_idx;
            r_data <= w_data;
            r_last <= w_last;
         end

         // Cleared on entry to GRANT and on every handshake
         if ((w_next == S_GRANT && !w_in_grant) || w_hs) r_icnt <= '0;
         else if (w_in_grant)                           r_icnt <= r_icnt + 1'b1;

         if (r_state == S_GAP) r_wcount <= r_wcount + 16'd1;
      end
   end

   for (genvar g = 0; g < NREQ; g++) begin : g_lane
      debug_cfg_lane u_lane (
         .clk        (clk),
         .MRST       (MRST),
         .i_own      (r_gnt[g]),
         .i_in_grant (w_in_grant),
         .i_err_evt  (w_err_evt),
         .i_clr_err  (clr_err),
         .o_wr_ready (wr_ready[g]),
         .o_err      (err[g])
      );
   end

   always_comb begin
      DCP = 32'd0;
      case (r_state)
         S_HDR:   DCP = {1'b1, 27'd0, r_idx};
         S_DATA:  DCP = r_data;
         default: DCP = 32'd0;
      endcase
   end

   assign gnt    = r_gnt;
   assign Sel    = r_sel;
   assign busy   = r_busy;
   assign wcount = r_wcount;
endmodule

// File: tb/tb_debug_cfg_arbiter.sv
module tb_debug_cfg_arbiter;
   logic        clk = 1'b0;
   logic        MRST;
   logic [2:0]  req;
   logic [2:0]  wr_valid;
   logic [11:0] wr_idx;
   logic [95:0] wr_data;
   logic [2:0]  wr_last;
   logic [2:0]  gnt;
   logic [2:0]  wr_ready;
   logic [31:0] DCP;
   logic [1:0]  Sel;
   logic        busy;
   logic [2:0]  err;
   logic        clr_err;
   logic [15:0] wcount;

   int n_chk  = 0;
   int n_fail = 0;

   debug_cfg_arbiter #(.NCFR(10), .TIMEOUT(16)) dut (
      .clk(clk), .MRST(MRST), .req(req), .wr_valid(wr_valid), .wr_idx(wr_idx),
      .wr_data(wr_data), .wr_last(wr_last), .gnt(gnt), .wr_ready(wr_ready),
      .DCP(DCP), .Sel(Sel), .busy(busy), .err(err), .clr_err(clr_err),
      .wcount(wcount)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one write from requester o in GRANT and take the handshake edge.
   task automatic wr(input int o, input logic [3:0] idx, input logic [31:0] d, input logic l);
      logic [2:0] rdy;
      rdy = 3'b001 << o;
      wr_valid = 3'b000;
      wr_valid[o] = 1'b1;
      wr_idx[4*o +: 4]   = idx;
      wr_data[32*o +: 32] = d;
      wr_last[o] = l;
      #1 chk("wr_ready", 32'(wr_ready), 32'(rdy));
      tick;
      wr_valid = 3'b000;
      wr_last  = 3'b000;
   endtask

   // Check header / data / gap; leaves time in the GAP cycle.
   task automatic seq(input string tag, input logic [31:0] hdr, input logic [31:0] d,
                      input logic [2:0] g);
      chk({tag, "_hdr"}, DCP, hdr);
      chk({tag, "_gnt_h"}, 32'(gnt), 32'(g));
      tick;
      chk({tag, "_data"}, DCP, d);
      chk({tag, "_gnt_d"}, 32'(gnt), 32'(g));
      tick;
      chk({tag, "_gap"}, DCP, 32'd0);
      chk({tag, "_gnt_g"}, 32'(gnt), 32'(g));
   endtask

   initial begin
      MRST = 1'b1; req = 3'b0; wr_valid = 3'b0; wr_idx = '0; wr_data = '0;
      wr_last = 3'b0; clr_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt",   32'(gnt), 32'd0);
      chk("rst_rdy",   32'(wr_ready), 32'd0);
      chk("rst_dcp",   DCP, 32'd0);
      chk("rst_sel",   32'(Sel), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_err",   32'(err), 32'd0);
      chk("rst_wcnt",  32'(wcount), 32'd0);
      MRST = 1'b0;

      // 1: single SPI write
      req = 3'b100;
      tick;
      chk("t1_gnt",  32'(gnt), 32'h4);
      chk("t1_sel",  32'(Sel), 32'h3);
      chk("t1_busy", 32'(busy), 32'h1);
      wr(2, 4'd3, 32'h0000_00A5, 1'b1);
      req = 3'b000;
      seq("t1", 32'h8000_0003, 32'h0000_00A5, 3'b100);
      chk("t1_wcnt_gap", 32'(wcount), 32'd0);
      tick;
      chk("t1_rel_gnt",  32'(gnt), 32'd0);
      chk("t1_rel_busy", 32'(busy), 32'd0);
      chk("t1_rel_sel",  32'(Sel), 32'd0);
      chk("t1_wcnt",     32'(wcount), 32'd1);
      tick;

      // 2: simultaneous requests, SPI then debugger then CPU
      req = 3'b111;
      tick;
      chk("t2_gnt_spi", 32'(gnt), 32'h4);
      wr(2, 4'd1, 32'h0000_0011, 1'b1);
      req = 3'b011;
      seq("t2s", 32'h8000_0001, 32'h0000_0011, 3'b100);
      tick;
      chk("t2_rel1_busy", 32'(busy), 32'd0);
      tick;
      chk("t2_idle1_busy", 32'(busy), 32'd0);
      chk("t2_idle1_gnt",  32'(gnt), 32'd0);
      tick;
      chk("t2_gnt_dbg", 32'(gnt), 32'h2);
      chk("t2_sel_dbg", 32'(Sel), 32'h2);
      wr(1, 4'd2, 32'h0000_0022, 1'b1);
      req = 3'b001;
      seq("t2d", 32'h8000_0002, 32'h0000_0022, 3'b010);
      tick;
      tick;
      chk("t2_idle2_gnt", 32'(gnt), 32'd0);
      tick;
      chk("t2_gnt_cpu", 32'(gnt), 32'h1);
      chk("t2_sel_cpu", 32'(Sel), 32'h1);
      wr(0, 4'd4, 32'h0000_0033, 1'b1);
      req = 3'b000;
      seq("t2c", 32'h8000_0004, 32'h0000_0033, 3'b001);
      tick;
      tick;
      chk("t2_wcnt", 32'(wcount), 32'd4);

      // 3: debugger burst of three
      req = 3'b010;
      tick;
      chk("t3_gnt", 32'(gnt), 32'h2);
      for (int k = 0; k < 3; k++) begin
         wr(1, 4'(k), 32'h1111_0000 + 32'(k), (k == 2));
         if (k == 2) req = 3'b000;
         seq("t3", 32'h8000_0000 + 32'(k), 32'h1111_0000 + 32'(k), 3'b010);
         tick;
         if (k < 2) chk("t3_gnt_held", 32'(gnt), 32'h2);
      end
      chk("t3_rel_gnt", 32'(gnt), 32'd0);
      chk("t3_wcnt",    32'(wcount), 32'd7);
      tick;

      // 4: illegal writes from the CPU, then clear
      req = 3'b001;
      tick;
      wr(0, 4'd12, 32'h0000_0000, 1'b0);
      chk("t4_idx12_dcp", DCP, 32'd0);
      chk("t4_idx12_err", 32'(err), 32'h1);
      chk("t4_idx12_gnt", 32'(gnt), 32'h1);
      wr(0, 4'd10, 32'h0000_0000, 1'b0);
      chk("t4_idx10_dcp", DCP, 32'd0);
      chk("t4_idx10_gnt", 32'(gnt), 32'h1);
      wr(0, 4'd1, 32'h8000_0001, 1'b1);
      req = 3'b000;
      chk("t4_d31_dcp",  DCP, 32'd0);
      chk("t4_d31_gnt",  32'(gnt), 32'd0);
      chk("t4_d31_err",  32'(err), 32'h1);
      chk("t4_wcnt",     32'(wcount), 32'd7);
      clr_err = 1'b1;
      tick;
      clr_err = 1'b0;
      chk("t4_clr_err", 32'(err), 32'd0);

      // Boundary legal write: idx NCFR-1, data[31] clear
      req = 3'b100;
      tick;
      wr(2, 4'd9, 32'h7FFF_FFFF, 1'b1);
      req = 3'b000;
      seq("t4b", 32'h8000_0009, 32'h7FFF_FFFF, 3'b100);
      tick;
      chk("t4b_wcnt", 32'(wcount), 32'd8);
      chk("t4b_err",  32'(err), 32'd0);
      tick;

      // 5: CPU idle grant times out after 16 GRANT cycles
      req = 3'b001;
      tick;
      chk("t5_gnt", 32'(gnt), 32'h1);
      repeat (15) tick;
      chk("t5_gnt_16th", 32'(gnt), 32'h1);
      chk("t5_err_16th", 32'(err), 32'd0);
      tick;
      chk("t5_rel_gnt",  32'(gnt), 32'd0);
      chk("t5_rel_busy", 32'(busy), 32'd0);
      chk("t5_to_err",   32'(err), 32'h1);
      tick;
      tick;
      chk("t5_regrant", 32'(gnt), 32'h1);
      wr(0, 4'd5, 32'h0000_1234, 1'b1);
      chk("t5_hdr", DCP, 32'h8000_0005);
      tick;
      chk("t5_data", DCP, 32'h0000_1234);
      MRST = 1'b1;
      #1;
      chk("mrst_dcp",  DCP, 32'd0);
      chk("mrst_gnt",  32'(gnt), 32'd0);
      chk("mrst_sel",  32'(Sel), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_err",  32'(err), 32'd0);
      chk("mrst_wcnt", 32'(wcount), 32'd0);
      chk("mrst_rdy",  32'(wr_ready), 32'd0);
      req = 3'b000;
      tick;
      MRST = 1'b0;
      tick;
      chk("post_rst_gnt", 32'(gnt), 32'd0);
      chk("post_rst_dcp", DCP, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/debug_cfg_arbiter.md
# debug_cfg_arbiter

Arbitrates access to the debug unit's configuration port (DCP/Sel) between three requesters: the security policy engine (SPI), the external debugger, and the on-chip processor. The winner streams register writes as (index, data) pairs. The block serialises each write into the debug unit's header/data/gap DCP protocol, drives Sel with the owner code, and rejects illegal writes. It sits between the requesters and the debug logic's DCP/Sel inputs.

## Interface
- NCFR, 10: number of CFR registers; legal indices are 0..NCFR-1.
- TIMEOUT, 16: idle-grant cycles before forced release (minimum 2).
- clk  in  1  system clock.
- MRST  in  1  reset, asynchronous, active-high.
- req  in  3  access request; bit0 = CPU, bit1 = external debugger, bit2 = SPI.
- wr_valid  in  3  per-requester write valid.
- wr_idx  in  12  per-requester CFR index, 4 bits each, requester i at [4i+3:4i].
- wr_data  in  96  per-requester data word, requester i at [32i+31:32i].
- wr_last  in  3  marks the final write of the burst.
- gnt  out  3  one-hot grant.
- wr_ready  out  3  write accepted this cycle.
- DCP  out  32  debug configuration port.
- Sel  out  2  owner code to the debug unit: 00 none, 01 CPU, 10 external debugger, 11 SPI.
- busy  out  1  a grant is active.
- err  out  3  sticky per-requester error flags.
- clr_err  in  1  synchronous clear of err.
- wcount  out  16  count of writes issued to DCP; wraps.

## Operation
- FSM states: IDLE, GRANT, HDR, DATA, GAP, REL.
- IDLE: if any req bit is set, grant by fixed priority SPI > debugger > CPU. Load gnt, Sel and busy, then go to GRANT.
- GRANT: wr_ready[owner] = 1 combinationally; all other wr_ready bits are 0. On wr_valid[owner], capture idx, data and last.
  - Legal write (idx < NCFR and data[31] = 0): go to HDR.
  - Illegal write: set err[owner] and do not issue. Go to REL if last, else stay in GRANT.
- HDR: DCP = {1'b1, 27'd0, idx}. Go to DATA.
- DATA: DCP = captured data. Go to GAP.
- GAP: DCP = 0 and wcount increments. Go to REL if last, else GRANT.
- REL: gnt = 0, Sel = 00, busy = 0, DCP = 0. Go to IDLE. This forces one idle cycle between owners.
- Release from GRANT goes to REL when either:
  - req[owner] drops with no valid write presented that cycle; or
  - the idle counter reaches TIMEOUT. In this case also set err[owner].
- Idle counter: counts consecutive GRANT cycles without wr_valid[owner]. It clears on any handshake and on entering GRANT.
- No preemption. A higher-priority request waits until REL.
- err: bits are set by events and cleared by clr_err. If set and clear occur in the same cycle, set wins.
- DCP is 0 in every state other than HDR and DATA. Sel and gnt are stable from the cycle after IDLE through the cycle before REL.

## Timing
- Reset values: gnt = 0, wr_ready = 0, DCP = 0, Sel = 00, busy = 0, err = 0, wcount = 0, FSM in IDLE, idle counter = 0.
- Reset is asynchronous. Asserting MRST mid-burst abandons the write and forces all outputs to reset values immediately.
- Latency:
  - req to gnt: 1 cycle.
  - Handshake to header on DCP: 1 cycle.
  - Header, data and gap occupy 3 consecutive cycles.
- Throughput: one legal write per 4 cycles (GRANT, HDR, DATA, GAP).
- Minimum owner turnaround: the last GAP, REL, IDLE, then the new grant — 3 cycles with busy = 0 for 2 of them.
- wcount wraps 16'hFFFF -> 0.
- Simultaneous requests in IDLE: the highest-priority request wins. The others see gnt = 0 and must hold req.

## Test plan
- SPI req with a single write, idx = 3, data = 32'h0000_00A5, last = 1 -> gnt = 100 and Sel = 11 next cycle. DCP then shows 32'h8000_0003, 32'h0000_00A5, 0 on consecutive cycles. wcount = 1, then REL.
- CPU and debugger request in the same cycle as SPI -> SPI is served first. Next comes the debugger (Sel = 10), then the CPU (Sel = 01), each preceded by a REL/IDLE gap.
- Debugger burst of 3 writes (idx 0, 1, 2) -> three 4-cycle DCP sequences, wcount = 3, gnt held throughout.
- CPU write with idx = 12, then one with data = 32'h8000_0001 -> no DCP activity and err[0] = 1. clr_err then gives err = 0.
- CPU granted and never asserts wr_valid (TIMEOUT = 16) -> release after 16 GRANT cycles with err[0] = 1. Asserting MRST during a DATA cycle clears DCP to 0 immediately.
